// File: rtl/fll_nco_pkg.sv
// Shared constants and helpers for the FLL-steered sine/cosine NCO.
package fll_nco_pkg;

  // Register map
  localparam logic [2:0] ADDR_FTW     = 3'd0;
  localparam logic [2:0] ADDR_GAIN    = 3'd1;
  localparam logic [2:0] ADDR_CTRL    = 3'd2;
  localparam logic [2:0] ADDR_LOCKTHR = 3'd3;

  // CTRL register bit positions
  localparam int CTRL_LOOP_EN = 0;
  localparam int CTRL_HOLD    = 1;

  // Tuning word for a frequency in Hz, rounded to nearest: hz * 2^phase_w / clk_ref
  function automatic longint unsigned calc_ftw(input longint unsigned hz,
                                               input longint unsigned clk_ref,
                                               input int unsigned     phase_w);
    longint unsigned num;
    num = hz << phase_w;
    return (num + (clk_ref >> 1)) / clk_ref;
  endfunction

endpackage

// File: rtl/nco_sincos_lut.sv
// Quarter-wave sine ROM with quadrant mirror/negate; two read ports share one table.
// Holds output stages 2 (mirrored ROM read) and 3 (sign apply and output register).
module nco_sincos_lut
  import fll_nco_pkg::*;
#(
  parameter int OUT_W  = 16,
  parameter int LUT_AW = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic                    vld_i,
  input  logic [LUT_AW+1:0]       pt_a_i,
  input  logic [LUT_AW+1:0]       pt_b_i,
  output logic signed [OUT_W-1:0] a_o,
  output logic signed [OUT_W-1:0] b_o,
  output logic                    vld_o
);

  localparam int               LUT_N = 2**LUT_AW + 1;
  localparam real              PI    = 3.14159265358979323846;
  localparam real              AMP   = real'(2**(OUT_W-1) - 1);
  localparam logic [LUT_AW:0]  Q_LEN = {1'b1, {LUT_AW{1'b0}}};

  // Quarter-wave table, entries 0 .. 2^LUT_AW inclusive so the mirror never needs an offset
  logic [OUT_W-2:0] rom [LUT_N];

  for (genvar gi = 0; gi < LUT_N; gi++) begin : g_rom
    localparam real ANG = real'(gi) * PI / real'(2**(LUT_AW+1));
    localparam int  VAL = $rtoi(AMP * $sin(ANG) + 0.5);
    assign rom[gi] = VAL[OUT_W-2:0];
  end

  // Quadrants 1 and 3 walk the quarter wave backwards
  function automatic logic [LUT_AW:0] rom_addr(input logic [LUT_AW+1:0] pt);
    if (pt[LUT_AW]) return Q_LEN - {1'b0, pt[LUT_AW-1:0]};
    return {1'b0, pt[LUT_AW-1:0]};
  endfunction

  // Quadrants 2 and 3 are the negative half-wave
  function automatic logic signed [OUT_W-1:0] apply_sign(input logic [OUT_W-2:0] mag,
                                                         input logic            neg);
    logic signed [OUT_W-1:0] v;
    v = $signed({1'b0, mag});
    return neg ? -v : v;
  endfunction

  logic [OUT_W-2:0] mag_a_p1, mag_b_p1;
  logic             neg_a_p1, neg_b_p1;
  logic             vld_p1;

  // Stage 2: mirrored ROM read for both ports
  always_ff @(posedge clk) begin
    if (en_i) begin
      mag_a_p1 <= rom[rom_addr(pt_a_i)];
      mag_b_p1 <= rom[rom_addr(pt_b_i)];
      neg_a_p1 <= pt_a_i[LUT_AW+1];
      neg_b_p1 <= pt_b_i[LUT_AW+1];
    end
  end

  // Stage 2 valid
  always_ff @(posedge clk) begin
    if (reset)     vld_p1 <= 1'b0;
    else if (en_i) vld_p1 <= vld_i;
  end

  // Stage 3: sign apply and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      a_o   <= '0;
      b_o   <= '0;
      vld_o <= 1'b0;
    end else if (en_i) begin
      a_o   <= apply_sign(mag_a_p1, neg_a_p1);
      b_o   <= apply_sign(mag_b_p1, neg_b_p1);
      vld_o <= vld_p1;
    end
  end

endmodule

// File: rtl/fll_nco_gen.sv
// FLL-steered NCO: gain-scaled FTW correction with window clamp, phase accumulator,
// quarter-wave sin/cos output pipeline and |delta| lock detector.
module fll_nco_gen
  import fll_nco_pkg::*;
#(
  parameter int CLK_REF      = 50_000_000,
  parameter int FRQ_SIGNAL   = 440_000,
  parameter int FRQ_DELT     = 44_000,
  parameter int PHASE_W      = 32,
  parameter int OUT_W        = 16,
  parameter int LUT_AW       = 10,
  parameter int DELTA_W      = 32,
  parameter int GAIN_W       = 20,
  parameter int GAIN_SHIFT   = 16,
  parameter int GAIN_DEF     = 65_536,
  parameter int LOCK_THR_DEF = 64,
  parameter int LOCK_CNT     = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic                      wr_en,
  input  logic [2:0]                address,
  input  logic [31:0]               wr_data,
  input  logic signed [DELTA_W-1:0] delta,
  input  logic                      delta_valid,
  output logic signed [OUT_W-1:0]   sin,
  output logic signed [OUT_W-1:0]   cos,
  output logic                      valid_gen,
  output logic                      locked,
  output logic                      sat,
  output logic [PHASE_W-1:0]        ftw
);

  localparam logic [PHASE_W-1:0] FTW_NOM =
    PHASE_W'(calc_ftw(64'(FRQ_SIGNAL), 64'(CLK_REF), PHASE_W));
  localparam logic [PHASE_W-1:0] FTW_MIN =
    PHASE_W'(calc_ftw(64'(FRQ_SIGNAL - FRQ_DELT), 64'(CLK_REF), PHASE_W));
  localparam logic [PHASE_W-1:0] FTW_MAX =
    PHASE_W'(calc_ftw(64'(FRQ_SIGNAL + FRQ_DELT), 64'(CLK_REF), PHASE_W));

  localparam int PROD_W = DELTA_W + GAIN_W + 1;
  // Wide enough that ftw - corr can never wrap
  localparam int NEXT_W = ((PROD_W > PHASE_W) ? PROD_W : PHASE_W + 1) + 1;
  localparam int PT_W   = LUT_AW + 2;
  localparam int CNT_W  = $clog2(LOCK_CNT + 1);

  localparam logic signed [NEXT_W-1:0] LIM_MIN = {{(NEXT_W-PHASE_W){1'b0}}, FTW_MIN};
  localparam logic signed [NEXT_W-1:0] LIM_MAX = {{(NEXT_W-PHASE_W){1'b0}}, FTW_MAX};
  localparam logic [GAIN_W-1:0]        GAIN_RST = GAIN_W'(GAIN_DEF);
  localparam logic [DELTA_W-1:0]       THR_RST  = DELTA_W'(LOCK_THR_DEF);
  localparam logic [CNT_W-1:0]         CNT_MAX  = CNT_W'(LOCK_CNT);
  localparam logic [DELTA_W-1:0]       NEG_MIN  = {1'b1, {(DELTA_W-1){1'b0}}};
  localparam logic [PT_W-1:0]          QUARTER  = {2'b01, {LUT_AW{1'b0}}};

  // Unsigned gain times signed delta at full product width
  function automatic logic signed [PROD_W-1:0] scale_err(input logic [GAIN_W-1:0]        g,
                                                         input logic signed [DELTA_W-1:0] d);
    logic signed [PROD_W-1:0] gs, ds;
    gs = {{(DELTA_W+1){1'b0}}, g};
    ds = {{(GAIN_W+1){d[DELTA_W-1]}}, d};
    return gs * ds;
  endfunction

  // Saturate to the frequency window; MSB of the result flags a clamp
  function automatic logic [PHASE_W:0] clamp_ftw(input logic signed [NEXT_W-1:0] v);
    if (v < LIM_MIN) return {1'b1, FTW_MIN};
    if (v > LIM_MAX) return {1'b1, FTW_MAX};
    return {1'b0, v[PHASE_W-1:0]};
  endfunction

  // The most negative delta has no positive magnitude and never counts as in-threshold
  function automatic logic within_thr(input logic signed [DELTA_W-1:0] d,
                                      input logic [DELTA_W-1:0]        thr);
    logic [DELTA_W-1:0] mag;
    if (d == NEG_MIN) return 1'b0;
    mag = d[DELTA_W-1] ? DELTA_W'(-d) : d;
    return mag <= thr;
  endfunction

  logic [PHASE_W-1:0]       ftw_q, ftw_d;
  logic                     sat_q, sat_d;
  logic [GAIN_W-1:0]        gain_q;
  logic [DELTA_W-1:0]       lock_thr_q;
  logic                     loop_en_q, hold_q;
  logic [PHASE_W-1:0]       phase_q;
  logic [CNT_W-1:0]         lock_cnt_q, lock_cnt_d;
  logic                     locked_q, locked_d;

  logic                     s1_en;
  logic signed [PROD_W-1:0] prod_p1;
  logic                     vld_p1;
  logic signed [PROD_W-1:0] corr;
  logic signed [NEXT_W-1:0] next_ftw;
  logic [PHASE_W:0]         clamped;

  logic [PT_W-1:0]          pt_sin_p0, pt_cos_p0;
  logic                     out_vld_p0;

  assign s1_en = delta_valid & loop_en_q & ~hold_q;

  // Loop stage 1: gain * delta
  always_ff @(posedge clk) begin
    if (s1_en) prod_p1 <= scale_err(gain_q, delta);
  end

  // Loop stage 1 valid; a disabled or held loop drops whatever was in flight
  always_ff @(posedge clk) begin
    if (reset) vld_p1 <= 1'b0;
    else       vld_p1 <= s1_en;
  end

  // Loop stage 2: scale down, subtract, clamp; a raw FTW write overrides the update
  always_comb begin
    corr     = prod_p1 >>> GAIN_SHIFT;
    next_ftw = {{(NEXT_W-PHASE_W){1'b0}}, ftw_q} - {{(NEXT_W-PROD_W){corr[PROD_W-1]}}, corr};
    clamped  = clamp_ftw(next_ftw);
    ftw_d    = ftw_q;
    sat_d    = sat_q;
    if (wr_en && address == ADDR_FTW) begin
      ftw_d = PHASE_W'(wr_data);
    end else if (vld_p1 && loop_en_q && !hold_q) begin
      ftw_d = clamped[PHASE_W-1:0];
      sat_d = clamped[PHASE_W];
    end
  end

  // Configuration registers and tuning word
  always_ff @(posedge clk) begin
    if (reset) begin
      ftw_q      <= FTW_NOM;
      sat_q      <= 1'b0;
      gain_q     <= GAIN_RST;
      lock_thr_q <= THR_RST;
      loop_en_q  <= 1'b0;
      hold_q     <= 1'b0;
    end else begin
      ftw_q <= ftw_d;
      sat_q <= sat_d;
      if (wr_en) begin
        case (address)
          ADDR_GAIN:    gain_q     <= wr_data[GAIN_W-1:0];
          ADDR_CTRL: begin
            loop_en_q <= wr_data[CTRL_LOOP_EN];
            hold_q    <= wr_data[CTRL_HOLD];
          end
          ADDR_LOCKTHR: lock_thr_q <= wr_data[DELTA_W-1:0];
          default: ;
        endcase
      end
    end
  end

  // Lock detector next state
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (!loop_en_q) begin
      lock_cnt_d = '0;
      locked_d   = 1'b0;
    end else if (delta_valid) begin
      if (within_thr(delta, lock_thr_q)) begin
        if (lock_cnt_q != CNT_MAX) lock_cnt_d = lock_cnt_q + 1'b1;
        locked_d = (lock_cnt_d == CNT_MAX);
      end else begin
        lock_cnt_d = '0;
        locked_d   = 1'b0;
      end
    end
  end

  // Lock detector state
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  // Phase accumulator and output stage 1 valid
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= '0;
      out_vld_p0 <= 1'b0;
    end else if (clk_en) begin
      phase_q    <= phase_q + ftw_q;
      out_vld_p0 <= 1'b1;
    end
  end

  // Output stage 1: quadrant and index for sine and for cosine (quarter turn ahead)
  always_ff @(posedge clk) begin
    if (clk_en) begin
      pt_sin_p0 <= phase_q[PHASE_W-1 -: PT_W];
      pt_cos_p0 <= phase_q[PHASE_W-1 -: PT_W] + QUARTER;
    end
  end

  nco_sincos_lut #(
    .OUT_W  (OUT_W),
    .LUT_AW (LUT_AW)
  ) u_lut (
    .clk    (clk),
    .reset  (reset),
    .en_i   (clk_en),
    .vld_i  (out_vld_p0),
    .pt_a_i (pt_sin_p0),
    .pt_b_i (pt_cos_p0),
    .a_o    (sin),
    .b_o    (cos),
    .vld_o  (valid_gen)
  );

  assign ftw    = ftw_q;
  assign sat    = sat_q;
  assign locked = locked_q;

endmodule

// File: tb/tb_fll_nco_gen.sv
// Directed testbench for fll_nco_gen.
module tb_fll_nco_gen;

  localparam longint NOM  = 37_795_712;
  localparam longint FMIN = 34_016_141;
  localparam longint FMAX = 41_575_283;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               clk_en = 1'b0;
  logic               wr_en = 1'b0;
  logic [2:0]         address = 3'd0;
  logic [31:0]        wr_data = 32'd0;
  logic signed [31:0] delta = 32'sd0;
  logic               delta_valid = 1'b0;
  logic signed [15:0] sin, cos;
  logic               valid_gen, locked, sat;
  logic [31:0]        ftw;

  int checks = 0;
  int errors = 0;

  fll_nco_gen dut (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .wr_en       (wr_en),
    .address     (address),
    .wr_data     (wr_data),
    .delta       (delta),
    .delta_valid (delta_valid),
    .sin         (sin),
    .cos         (cos),
    .valid_gen   (valid_gen),
    .locked      (locked),
    .sat         (sat),
    .ftw         (ftw)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint exp_sin;
    longint exp_cos;
  } sc_vec_t;

  typedef struct {
    longint start;
    longint gain;
    longint dlt;
    longint exp_ftw;
    longint exp_sat;
  } lp_vec_t;

  sc_vec_t sc_tab[4];
  lp_vec_t lp_tab[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic wr_reg(input logic [2:0] a, input longint d);
    address = a;
    wr_data = 32'(d);
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic pulse(input longint d);
    delta       = 32'(d);
    delta_valid = 1'b1;
    tick();
    delta_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    clk_en = 1'b0;
    tick();
    tick();
    reset  = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sc_tab[0] = '{0, 32767};
    sc_tab[1] = '{32767, 0};
    sc_tab[2] = '{0, -32767};
    sc_tab[3] = '{-32767, 0};

    lp_tab[0] = '{NOM, 65536, 1000, 37_794_712, 0};
    lp_tab[1] = '{NOM, 65536, -1073741824, FMAX, 1};
    lp_tab[2] = '{NOM, 65536, 1073741824, FMIN, 1};
    lp_tab[3] = '{NOM, 131072, -500, 37_796_712, 0};
    lp_tab[4] = '{NOM, 32768, 7, 37_795_709, 0};
    lp_tab[5] = '{NOM, 32768, -7, 37_795_716, 0};
    lp_tab[6] = '{41_575_278, 65536, -10, FMAX, 1};

    // Reset state
    do_reset();
    check("rst_ftw", ftw, NOM);
    check("rst_sin", sin, 0);
    check("rst_cos", cos, 0);
    check("rst_valid", valid_gen, 0);
    check("rst_locked", locked, 0);
    check("rst_sat", sat, 0);

    // First accumulator step and valid_gen latency
    clk_en = 1'b1;
    tick();
    check("phase_step1", dut.phase_q, NOM);
    check("ftw_step1", ftw, NOM);
    check("valid_after1", valid_gen, 0);
    tick();
    check("valid_after2", valid_gen, 0);
    tick();
    check("valid_after3", valid_gen, 1);

    // Quarter-turn tuning word: sin/cos walk the four quadrant points
    do_reset();
    wr_reg(3'd0, 64'd1 << 30);
    clk_en = 1'b1;
    tick();
    tick();
    check("sc_valid_pre", valid_gen, 0);
    tick();
    check("sc_valid", valid_gen, 1);
    for (int m = 0; m < 8; m++) begin
      check($sformatf("sin_%0d", m), sin, sc_tab[m % 4].exp_sin);
      check($sformatf("cos_%0d", m), cos, sc_tab[m % 4].exp_cos);
      if (m == 3) begin
        clk_en = 1'b0;
        tick();
        tick();
        check("freeze_sin", sin, sc_tab[3].exp_sin);
        check("freeze_cos", cos, sc_tab[3].exp_cos);
        clk_en = 1'b1;
      end
      tick();
    end

    // Loop update vectors
    wr_reg(3'd2, 1);
    for (int i = 0; i < 7; i++) begin
      wr_reg(3'd0, lp_tab[i].start);
      wr_reg(3'd1, lp_tab[i].gain);
      pulse(lp_tab[i].dlt);
      check($sformatf("lp%0d_ftw_s1", i), ftw, lp_tab[i].start);
      tick();
      check($sformatf("lp%0d_ftw", i), ftw, lp_tab[i].exp_ftw);
      check($sformatf("lp%0d_sat", i), sat, lp_tab[i].exp_sat);
    end

    // Hold freezes the tuning word
    wr_reg(3'd0, NOM);
    wr_reg(3'd1, 65536);
    wr_reg(3'd2, 3);
    pulse(1000);
    tick();
    tick();
    check("hold_ftw", ftw, NOM);

    // Lock after 256 in-threshold deltas, drop on one outlier
    wr_reg(3'd2, 0);
    wr_reg(3'd1, 0);
    wr_reg(3'd2, 1);
    delta       = 32'sd10;
    delta_valid = 1'b1;
    repeat (255) tick();
    check("lock_255", locked, 0);
    tick();
    check("lock_256", locked, 1);
    delta = 32'sd100;
    tick();
    delta_valid = 1'b0;
    check("lock_drop", locked, 0);
    check("lock_ftw", ftw, NOM);

    // Near-full-scale deltas with a wide threshold, loop_en clear, most-negative delta
    wr_reg(3'd3, 64'hFFFF_FFFF);
    delta       = 32'sh8000_0001;
    delta_valid = 1'b1;
    repeat (256) tick();
    delta_valid = 1'b0;
    check("lock_wide", locked, 1);
    wr_reg(3'd2, 0);
    tick();
    check("lock_loopoff", locked, 0);
    wr_reg(3'd2, 1);
    delta       = 32'sh8000_0001;
    delta_valid = 1'b1;
    repeat (256) tick();
    check("lock_wide2", locked, 1);
    delta = 32'sh8000_0000;
    tick();
    delta_valid = 1'b0;
    check("lock_negmin", locked, 0);

    // Raw FTW write colliding with a stage-2 update
    wr_reg(3'd1, 65536);
    wr_reg(3'd0, NOM);
    pulse(-1073741824);
    tick();
    check("coll_pre_sat", sat, 1);
    wr_reg(3'd0, NOM);
    delta       = 32'sd1000;
    delta_valid = 1'b1;
    tick();
    delta_valid = 1'b0;
    address = 3'd0;
    wr_data = 32'd40_000_000;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
    check("coll_ftw", ftw, 40_000_000);
    check("coll_sat", sat, 1);
    tick();
    check("coll_ftw_late", ftw, 40_000_000);

    // Reset mid-stream
    check("pre_rst_valid", valid_gen, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_ftw", ftw, NOM);
    check("mid_rst_sin", sin, 0);
    check("mid_rst_cos", cos, 0);
    check("mid_rst_valid", valid_gen, 0);
    check("mid_rst_locked", locked, 0);
    check("mid_rst_sat", sat, 0);
    check("mid_rst_phase", dut.phase_q, 0);
    wr_reg(3'd2, 1);
    pulse(1000);
    tick();
    check("post_rst_gain", ftw, 37_794_712);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
